// File: rtl/pong_paddle_ctrl.sv
// rtl/pong_paddle_ctrl.sv - N-player paddle key tracking and clamped vertical movement; speed ramp enabled by PONG_PADDLE_ACCEL_EN
module pong_paddle_ctrl #(
  parameter int                        NUM_PLAYERS = 2,
  parameter logic [16*NUM_PLAYERS-1:0] KEY_UP      = 32'hE075_E027,
  parameter logic [16*NUM_PLAYERS-1:0] KEY_DOWN    = 32'hE072_E01F,
  parameter int                        Y_W         = 10,
  parameter int                        POS_Y       = 170,
  parameter int                        PAD_H       = 200,
  parameter int                        FIELD_TOP   = 0,
  parameter int                        FIELD_BOT   = 480,
  parameter int                        SPEED       = 1,
  parameter int                        MAX_SPEED   = 4,
  parameter int                        ACCEL_TICKS = 8
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       tick,
  input  logic [15:0]                scan_code,
  input  logic                       finished,
  input  logic                       break_code,
  output logic [NUM_PLAYERS*Y_W-1:0] pad_y,
  output logic [NUM_PLAYERS-1:0]     up_held,
  output logic [NUM_PLAYERS-1:0]     down_held,
  output logic [NUM_PLAYERS-1:0]     at_top,
  output logic [NUM_PLAYERS-1:0]     at_bot
);

  // Two extra bits give headroom so y-step and y+step never wrap before clamping.
  localparam int YS_W = Y_W + 2;
  localparam logic signed [YS_W-1:0] TOP_S   = YS_W'(FIELD_TOP);
  localparam logic signed [YS_W-1:0] BOT_S   = YS_W'(FIELD_BOT - PAD_H);
  localparam logic [Y_W-1:0]         POS_Y_V = Y_W'(POS_Y);
  localparam logic [YS_W-1:0]        SPEED_V = YS_W'(SPEED);

`ifdef PONG_PADDLE_ACCEL_EN
  localparam int              RC_W       = $clog2(ACCEL_TICKS + 1);
  localparam logic [RC_W-1:0] ACCEL_LAST = RC_W'(ACCEL_TICKS - 1);
  localparam logic [YS_W-1:0] MAX_V      = YS_W'(MAX_SPEED);
`else
  wire unused_accel_cfg = ^{32'(MAX_SPEED), 32'(ACCEL_TICKS)};
`endif

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    logic                   up_r;
    logic                   down_r;
    logic [Y_W-1:0]         y_r;
    logic [Y_W-1:0]         y_nxt;
    logic [YS_W-1:0]        step_cur;
    logic signed [YS_W-1:0] y_ext;
    logic signed [YS_W-1:0] y_dec;
    logic signed [YS_W-1:0] y_inc;
    logic [15:0]            code_up;
    logic [15:0]            code_dn;

    assign code_up = KEY_UP[16*g +: 16];
    assign code_dn = KEY_DOWN[16*g +: 16];

`ifdef PONG_PADDLE_ACCEL_EN
    logic [YS_W-1:0] step_r;
    logic [YS_W-1:0] step_nxt;
    logic [RC_W-1:0] run_r;
    logic [RC_W-1:0] run_nxt;
    logic [RC_W-1:0] run_base;
    logic            last_up_r;
    logic            last_dn_r;
    logic            same_dir;

    // Ramp: a tick whose direction differs from the previous tick restarts at SPEED and counts as the first run tick.
    always_comb begin
      same_dir = (up_r == last_up_r) && (down_r == last_dn_r);
      step_cur = same_dir ? step_r : SPEED_V;
      run_base = same_dir ? run_r : '0;
      step_nxt = SPEED_V;
      run_nxt  = '0;
      if (up_r || down_r) begin
        step_nxt = step_cur;
        if (run_base == ACCEL_LAST) begin
          if (step_cur < MAX_V) step_nxt = step_cur + YS_W'(1);
        end else begin
          run_nxt = run_base + RC_W'(1);
        end
      end
    end

    // Ramp state advances only on game ticks; idle ticks leave it at SPEED with an empty run.
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        step_r    <= SPEED_V;
        run_r     <= '0;
        last_up_r <= 1'b0;
        last_dn_r <= 1'b0;
      end else if (tick) begin
        step_r    <= step_nxt;
        run_r     <= run_nxt;
        last_up_r <= up_r;
        last_dn_r <= down_r;
      end
    end
`else
    assign step_cur = SPEED_V;
`endif

    // Next paddle row, clamped into [FIELD_TOP, FIELD_BOT-PAD_H] in the widened signed domain.
    always_comb begin
      y_ext = signed'({2'b00, y_r});
      y_dec = y_ext - signed'(step_cur);
      y_inc = y_ext + signed'(step_cur);
      y_nxt = y_r;
      if (up_r) begin
        y_nxt = (y_dec < TOP_S) ? TOP_S[Y_W-1:0] : y_dec[Y_W-1:0];
      end else if (down_r) begin
        y_nxt = (y_inc > BOT_S) ? BOT_S[Y_W-1:0] : y_inc[Y_W-1:0];
      end
    end

    // Key flags and position; movement reads the flags from before this edge, so a same-cycle key event waits a tick.
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        up_r   <= 1'b0;
        down_r <= 1'b0;
        y_r    <= POS_Y_V;
      end else begin
        if (finished) begin
          if (scan_code == code_up) begin
            if (break_code) begin
              up_r <= 1'b0;
            end else begin
              up_r   <= 1'b1;
              down_r <= 1'b0;
            end
          end else if (scan_code == code_dn) begin
            if (break_code) begin
              down_r <= 1'b0;
            end else begin
              down_r <= 1'b1;
              up_r   <= 1'b0;
            end
          end
        end
        if (tick) y_r <= y_nxt;
      end
    end

    assign pad_y[Y_W*g +: Y_W] = y_r;
    assign up_held[g]          = up_r;
    assign down_held[g]        = down_r;
    assign at_top[g]           = (y_r == TOP_S[Y_W-1:0]);
    assign at_bot[g]           = (y_r == BOT_S[Y_W-1:0]);
  end

endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// tb/tb_pong_paddle_ctrl.sv - directed self-checking bench for pong_paddle_ctrl
module tb_pong_paddle_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        tick;
  logic [15:0] scan_code;
  logic        finished;
  logic        break_code;
  logic [19:0] pad_y;
  logic [1:0]  up_held;
  logic [1:0]  down_held;
  logic [1:0]  at_top;
  logic [1:0]  at_bot;

  int checks   = 0;
  int failures = 0;
  int went_bad = 0;

  pong_paddle_ctrl dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .tick      (tick),
    .scan_code (scan_code),
    .finished  (finished),
    .break_code(break_code),
    .pad_y     (pad_y),
    .up_held   (up_held),
    .down_held (down_held),
    .at_top    (at_top),
    .at_bot    (at_bot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [15:0] code, input logic brk);
    @(negedge clk);
    scan_code  = code;
    break_code = brk;
    finished   = 1'b1;
    @(negedge clk);
    finished   = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  initial begin
    rst_b = 1'b0; tick = 1'b0; scan_code = 16'h0; finished = 1'b0; break_code = 1'b0;

    // Reset held while ticks and keys toggle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tick = ~tick; finished = ~finished; scan_code = (i % 2 == 0) ? 16'hE027 : 16'hE072;
    end
    @(negedge clk);
    chk("rst_p0", 32'(pad_y[9:0]), 32'd170);
    chk("rst_p1", 32'(pad_y[19:10]), 32'd170);
    chk("rst_up", 32'(up_held), 32'd0);
    chk("rst_dn", 32'(down_held), 32'd0);
    chk("rst_top", 32'(at_top), 32'd0);
    chk("rst_bot", 32'(at_bot), 32'd0);
    tick = 1'b0; finished = 1'b0; scan_code = 16'h0;
    @(negedge clk);
    rst_b = 1'b1;

    // p0 up three ticks
    key(16'hE027, 1'b0);
    chk("up_held_make", 32'(up_held), 32'd1);
    ticks(3);
    chk("p0_3ticks", 32'(pad_y[9:0]), 32'd167);
    chk("p1_still", 32'(pad_y[19:10]), 32'd170);

    // p0 runs into top bound, never wraps
    for (int i = 0; i < 200; i++) begin
      ticks(1);
      if (pad_y[9:0] > 10'd170) went_bad++;
    end
    chk("p0_top", 32'(pad_y[9:0]), 32'd0);
    chk("p0_no_wrap", 32'(went_bad), 32'd0);
    chk("at_top", 32'(at_top), 32'd1);

    // p1 down to bottom bound
    key(16'hE072, 1'b0);
    ticks(200);
    chk("p1_bot", 32'(pad_y[19:10]), 32'd280);
    chk("at_bot", 32'(at_bot), 32'd2);
    chk("p0_still_top", 32'(pad_y[9:0]), 32'd0);

    // Break of the other key leaves up held; make of down flips direction
    key(16'hE01F, 1'b1);
    chk("brk_other_up", 32'(up_held), 32'd1);
    key(16'hE01F, 1'b0);
    chk("flip_up", 32'(up_held), 32'd0);
    chk("flip_dn", 32'(down_held), 32'd3);
    ticks(1);
    chk("p0_down1", 32'(pad_y[9:0]), 32'd1);
    chk("p1_clamped", 32'(pad_y[19:10]), 32'd280);

    // finished and tick together: tick uses the old (down) direction
    @(negedge clk);
    scan_code = 16'hE027; break_code = 1'b0; finished = 1'b1; tick = 1'b1;
    @(negedge clk);
    finished = 1'b0; tick = 1'b0;
    chk("same_cyc_p0", 32'(pad_y[9:0]), 32'd2);
    chk("same_cyc_up", 32'(up_held), 32'd1);
    chk("same_cyc_dn", 32'(down_held), 32'd2);
    ticks(1);
    chk("new_dir_p0", 32'(pad_y[9:0]), 32'd1);

    // Unmatched code ignored; release p1 then press p1 up
    key(16'h1234, 1'b0);
    chk("unmatched_up", 32'(up_held), 32'd1);
    chk("unmatched_dn", 32'(down_held), 32'd2);
    key(16'hE072, 1'b1);
    chk("p1_release", 32'(down_held), 32'd0);
    ticks(1);
    chk("p0_top_again", 32'(pad_y[9:0]), 32'd0);
    chk("p1_idle", 32'(pad_y[19:10]), 32'd280);
    key(16'hE075, 1'b0);
    chk("p1_up_held", 32'(up_held), 32'd3);
    ticks(1);
    chk("p1_up1", 32'(pad_y[19:10]), 32'd279);

    // Async reset mid-hold after 5 ticks
    ticks(5);
    chk("p1_up6", 32'(pad_y[19:10]), 32'd274);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("async_p0", 32'(pad_y[9:0]), 32'd170);
    chk("async_p1", 32'(pad_y[19:10]), 32'd170);
    chk("async_up", 32'(up_held), 32'd0);
    chk("async_dn", 32'(down_held), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    ticks(1);
    chk("post_rst_idle", 32'(pad_y[19:10]), 32'd170);

`ifdef PONG_PADDLE_ACCEL_EN
    // Ramp: 8x1 + 8x2 + 4x3 = 36 rows in 20 ticks
    key(16'hE072, 1'b0);
    ticks(20);
    chk("accel_20", 32'(pad_y[19:10]), 32'd206);
    key(16'hE072, 1'b1);
    ticks(1);
    chk("accel_idle", 32'(pad_y[19:10]), 32'd206);
    key(16'hE072, 1'b0);
    ticks(1);
    chk("accel_restart", 32'(pad_y[19:10]), 32'd207);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_paddle_ctrl.md
# pong_paddle_ctrl

Parametrised paddle controller for the Pong design: tracks held/released state of per-player up/down keys from the PS/2 keyboard wrapper and moves `NUM_PLAYERS` paddles vertically on each game tick, clamped to the playfield. It sits between `keyboard_wrapper` and the renderer. It generalises the fixed two-player key decode plus `player` movement to N players, configurable keycodes, an explicit field range and an optional speed ramp.

## Interface
- `NUM_PLAYERS`, 2, number of paddles (1..8)
- `KEY_UP`, 32'hE075_E027, packed up scan codes; player i uses bits [16i+15:16i]
- `KEY_DOWN`, 32'hE072_E01F, packed down scan codes; same packing
- `Y_W`, 10, paddle Y width
- `POS_Y`, 170, reset Y of every paddle; must lie in [FIELD_TOP, FIELD_BOT-PAD_H]
- `PAD_H`, 200, paddle height in rows
- `FIELD_TOP`, 0, lowest legal Y
- `FIELD_BOT`, 480, one past last visible row
- `SPEED`, 1, base rows per tick
- `MAX_SPEED`, 4, step ceiling (accel build only)
- `ACCEL_TICKS`, 8, moving ticks per step increment (accel build only)

Ports:
- `clk`  in  1  system clock
- `rst_b`  in  1  reset, asynchronous, active-low
- `tick`  in  1  one-cycle game-tick strobe
- `scan_code`  in  16  scan code from keyboard wrapper
- `finished`  in  1  one-cycle strobe: `scan_code`/`break_code` valid
- `break_code`  in  1  1 = release, 0 = press
- `pad_y`  out  NUM_PLAYERS*Y_W  paddle top rows; player i at [Y_W*i+Y_W-1:Y_W*i]
- `up_held`  out  NUM_PLAYERS  registered up-key state
- `down_held`  out  NUM_PLAYERS  registered down-key state
- `at_top`  out  NUM_PLAYERS  pad_y == FIELD_TOP
- `at_bot`  out  NUM_PLAYERS  pad_y == FIELD_BOT-PAD_H

## Operation
- Key tracking, per player i, on a clock edge with `finished`=1:
  - code == KEY_UP[i]: break clears `up_held[i]`; make sets `up_held[i]` and clears `down_held[i]`.
  - Else code == KEY_DOWN[i]: break clears `down_held[i]`; make sets `down_held[i]` and clears `up_held[i]`.
  - Up match takes precedence if KEY_UP[i]==KEY_DOWN[i]. A code shared between players affects all matching players. Unmatched codes are ignored.
- The held flags are mutually exclusive by construction. Direction: UP if `up_held`, DOWN if `down_held`, else IDLE.
- Movement, on an edge with `tick`=1, per player:
  - UP: y <= max(FIELD_TOP, y - step).
  - DOWN: y <= min(FIELD_BOT-PAD_H, y + step).
  - IDLE: hold.
  - Arithmetic is done in Y_W+2 signed bits. No wrap-around is permitted at either bound.
- Per-player state: `step` (reset SPEED) and `run_cnt` (reset 0).
- `at_top`/`at_bot` decode combinationally from registered `pad_y`.

## Timing
- Reset (async assert, synchronous release on `clk`): every `pad_y` = POS_Y, `up_held`/`down_held` = 0, step = SPEED, run_cnt = 0. Assertion mid-move takes effect immediately; no partial update survives.
- Held flags update at the edge sampling `finished`=1 and are visible next cycle.
- `pad_y` updates at the edge sampling `tick`=1 (1-cycle latency).
- `tick` and `finished` in the same cycle: movement uses the held flags from before that edge. The new key state first applies on the following tick.
- No handshake back to the keyboard wrapper; each `finished` strobe is consumed in one cycle.

## Configuration
- `PONG_PADDLE_ACCEL_EN` defined:
  - On each moving tick the position moves by `step`, then run_cnt increments.
  - When run_cnt reaches ACCEL_TICKS, run_cnt returns to 0 and step = min(step+1, MAX_SPEED).
  - A direction change or IDLE on a tick resets step to SPEED and run_cnt to 0.
  - Reaching a bound does not reset the ramp.
- Not defined: step fixed at SPEED. The ramp registers are absent, and MAX_SPEED/ACCEL_TICKS are ignored.

## Test plan
- Reset: hold `rst_b`=0 with ticks and keys toggling -> `pad_y`={170,170}, held=0, at_top=at_bot=0.
- Make E027, then 3 ticks (no accel) -> p0 Y 170→167; p1 stays 170; `up_held`=2'b01.
- Hold E027 for 200 ticks -> p0 Y settles at 0, `at_top[0]`=1, never 1023. Make E072 for 200 ticks -> p1 Y=280, `at_bot[1]`=1.
- With E027 held, break E01F -> `up_held[0]` stays 1. Make E01F -> up=0, down=1, next tick Y+1. `finished` and `tick` in the same cycle -> that tick uses the old direction.
- Accel build (SPEED 1, MAX 4, ACCEL_TICKS 8): hold E072 for 20 ticks from 170 -> Y=206 (8×1+8×2+4×3). Release and re-press -> step back to 1.
- Assert `rst_b` mid-hold after 5 ticks -> `pad_y` immediately 170, held flags cleared, step back to SPEED.
